// File: rtl/regfile_operand_stage.sv
// Operand-supply stage: 32x32 register file, ALU operand muxing, ZF/OF flag latch and overflow write block.
// Optional same-cycle write-to-read bypass is enabled by defining RF_WRITE_BYPASS_EN.
module regfile_operand_stage #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int REG_NUM = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic              w_en,
   input  logic              ovf_chk,
   input  logic              zf_in,
   input  logic              of_in,
   input  logic              flag_en,
   input  logic [15:0]       imm16,
   input  logic [4:0]        shamt,
   input  logic              sel_a_shamt,
   input  logic              sel_b_imm,
   input  logic              imm_sext,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [DATA_W-1:0] rt_data,
   output logic              zf_q,
   output logic              of_q,
   output logic              wr_blocked
);

   logic [DATA_W-1:0] r_regs [REG_NUM];
   logic              r_zf;
   logic              r_of;
   logic              r_wr_blocked;

   logic              w_addr_nz;
   logic              w_ovf_block;
   logic              w_wr_qual;
   logic [DATA_W-1:0] w_rs_data;
   logic [DATA_W-1:0] w_rt_data;
   logic [DATA_W-1:0] w_imm_ext;

   // A write to R0 is a no-op, so it can neither commit nor count as blocked.
   assign w_addr_nz   = (w_addr != '0);
   assign w_ovf_block = w_en && w_addr_nz && ovf_chk && of_in;
   assign w_wr_qual   = w_en && w_addr_nz && !(ovf_chk && of_in);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_qual) begin
         r_regs[w_addr] <= w_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_zf         <= 1'b0;
         r_of         <= 1'b0;
         r_wr_blocked <= 1'b0;
      end else begin
         r_wr_blocked <= w_ovf_block;
         if (flag_en) begin
            r_zf <= zf_in;
            r_of <= of_in;
         end
      end
   end

   always_comb begin
      w_rs_data = (rs_addr == '0) ? '0 : r_regs[rs_addr];
      w_rt_data = (rt_addr == '0) ? '0 : r_regs[rt_addr];
`ifdef RF_WRITE_BYPASS_EN
      // Bypass is gated by reset so reads stay zero while rst is held.
      if (!rst && w_wr_qual && (w_addr == rs_addr)) begin
         w_rs_data = w_data;
      end
      if (!rst && w_wr_qual && (w_addr == rt_addr)) begin
         w_rt_data = w_data;
      end
`endif
   end

   assign w_imm_ext = imm_sext ? {{(DATA_W-16){imm16[15]}}, imm16}
                               : {{(DATA_W-16){1'b0}}, imm16};

   assign A          = sel_a_shamt ? {{(DATA_W-5){1'b0}}, shamt} : w_rs_data;
   assign B          = sel_b_imm ? w_imm_ext : w_rt_data;
   assign rt_data    = w_rt_data;
   assign zf_q       = r_zf;
   assign of_q       = r_of;
   assign wr_blocked = r_wr_blocked;

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Self-checking bench for regfile_operand_stage: directed scenarios plus randomized cycles against a behavioural model.
module tb_regfile_operand_stage;

   logic        clk;
   logic        rst;
   logic [4:0]  rs_addr, rt_addr, w_addr;
   logic [31:0] w_data;
   logic        w_en, ovf_chk, zf_in, of_in, flag_en;
   logic [15:0] imm16;
   logic [4:0]  shamt;
   logic        sel_a_shamt, sel_b_imm, imm_sext;
   logic [31:0] A, B, rt_data;
   logic        zf_q, of_q, wr_blocked;

   int n_pass  = 0;
   int n_total = 0;

   // behavioural model state
   logic [31:0] exp_rf [32];
   logic        exp_zf, exp_of, exp_blk;

   regfile_operand_stage dut (
      .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .w_addr(w_addr),
      .w_data(w_data), .w_en(w_en), .ovf_chk(ovf_chk), .zf_in(zf_in), .of_in(of_in),
      .flag_en(flag_en), .imm16(imm16), .shamt(shamt), .sel_a_shamt(sel_a_shamt),
      .sel_b_imm(sel_b_imm), .imm_sext(imm_sext), .A(A), .B(B), .rt_data(rt_data),
      .zf_q(zf_q), .of_q(of_q), .wr_blocked(wr_blocked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
      exp_zf = 1'b0; exp_of = 1'b0; exp_blk = 1'b0;
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
`ifdef RF_WRITE_BYPASS_EN
      if (!rst && w_en && (w_addr == a) && !(ovf_chk && of_in)) return w_data;
`endif
      return exp_rf[a];
   endfunction

   function automatic logic [31:0] m_a();
      return sel_a_shamt ? 32'(shamt) : m_read(rs_addr);
   endfunction

   function automatic logic [31:0] m_b();
      if (!sel_b_imm) return m_read(rt_addr);
      return imm_sext ? 32'($signed(imm16)) : 32'(imm16);
   endfunction

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         exp_blk = w_en && (w_addr != 0) && ovf_chk && of_in;
         if (w_en && (w_addr != 0) && !(ovf_chk && of_in)) exp_rf[w_addr] = w_data;
         if (flag_en) begin exp_zf = zf_in; exp_of = of_in; end
      end
      #1;
   endtask

   task automatic set_idle();
      rs_addr = 0; rt_addr = 0; w_addr = 0; w_data = 0; w_en = 0; ovf_chk = 0;
      zf_in = 0; of_in = 0; flag_en = 0; imm16 = 0; shamt = 0;
      sel_a_shamt = 0; sel_b_imm = 0; imm_sext = 0;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      w_en = 1; w_addr = a; w_data = d; ovf_chk = 0;
      tick();
      w_en = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      // power-on reset held: every address reads zero
      for (int i = 0; i < 32; i += 7) begin
         rs_addr = 5'(i); rt_addr = 5'(31 - i); #1;
         n_total++; if (A !== 32'h0) $display("FAIL reset_a addr=%0d got=%h exp=0", i, A); else n_pass++;
         n_total++; if (rt_data !== 32'h0) $display("FAIL reset_rt addr=%0d got=%h exp=0", 31 - i, rt_data); else n_pass++;
      end
      n_total++; if ({zf_q, of_q, wr_blocked} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {zf_q, of_q, wr_blocked}); else n_pass++;
      @(negedge clk); rst = 0; #1;
      // mid-run reset after writes and flag set, with a write pending
      do_write(5'd4, 32'hCAFE0004);
      do_write(5'd9, 32'h12345678);
      flag_en = 1; zf_in = 1; of_in = 1; tick(); flag_en = 0; zf_in = 0; of_in = 0;
      w_en = 1; w_addr = 5'd4; w_data = 32'hBAD0BAD0; ovf_chk = 1; of_in = 1; tick();
      w_en = 1; w_addr = 5'd9; w_data = 32'h0BADF00D; ovf_chk = 0; of_in = 0;
      rs_addr = 5'd4; rt_addr = 5'd9; #2;
      rst = 1; model_reset(); #1;
      n_total++; if (A !== 32'h0) $display("FAIL midrst_a got=%h exp=0", A); else n_pass++;
      n_total++; if (rt_data !== 32'h0) $display("FAIL midrst_rt got=%h exp=0", rt_data); else n_pass++;
      n_total++; if ({zf_q, of_q, wr_blocked} !== 3'b000) $display("FAIL midrst_flags got=%b exp=000", {zf_q, of_q, wr_blocked}); else n_pass++;
      tick(); // edge under reset: pending write must not land
      @(negedge clk); rst = 0; set_idle(); rs_addr = 5'd9; #1;
      n_total++; if (A !== 32'h0) $display("FAIL midrst_abort got=%h exp=0", A); else n_pass++;
   endtask

   task automatic test_write_read();
      do_write(5'd5, 32'hDEADBEEF);
      rs_addr = 5'd5; #1;
      n_total++; if (A !== 32'hDEADBEEF) $display("FAIL wr_r5 got=%h exp=deadbeef", A); else n_pass++;
      do_write(5'd0, 32'h1);
      rs_addr = 5'd0; rt_addr = 5'd0; #1;
      n_total++; if (A !== 32'h0) $display("FAIL r0_a got=%h exp=0", A); else n_pass++;
      n_total++; if (B !== 32'h0) $display("FAIL r0_b got=%h exp=0", B); else n_pass++;
      n_total++; if (wr_blocked !== 1'b0) $display("FAIL r0_blk got=%b exp=0", wr_blocked); else n_pass++;
   endtask

   task automatic test_imm();
      rt_addr = 5'd5; sel_b_imm = 1; imm16 = 16'h8001; imm_sext = 1; #1;
      n_total++; if (B !== 32'hFFFF8001) $display("FAIL imm_sext got=%h exp=ffff8001", B); else n_pass++;
      imm_sext = 0; #1;
      n_total++; if (B !== 32'h00008001) $display("FAIL imm_zext got=%h exp=00008001", B); else n_pass++;
      n_total++; if (rt_data !== 32'hDEADBEEF) $display("FAIL rt_raw got=%h exp=deadbeef", rt_data); else n_pass++;
      sel_a_shamt = 1; shamt = 5'd31; rs_addr = 5'd5; #1;
      n_total++; if (A !== 32'h0000001F) $display("FAIL shamt got=%h exp=0000001f", A); else n_pass++;
      set_idle(); #1;
   endtask

   task automatic test_ovf();
      do_write(5'd3, 32'h11);
      w_en = 1; w_addr = 5'd3; w_data = 32'h7FFFFFFF; ovf_chk = 1; of_in = 1;
      tick();
      set_idle(); rs_addr = 5'd3; #1;
      n_total++; if (A !== 32'h11) $display("FAIL ovf_hold got=%h exp=00000011", A); else n_pass++;
      n_total++; if (wr_blocked !== 1'b1) $display("FAIL ovf_pulse got=%b exp=1", wr_blocked); else n_pass++;
      tick();
      n_total++; if (wr_blocked !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", wr_blocked); else n_pass++;
      w_en = 1; w_addr = 5'd3; w_data = 32'h7FFFFFFF; ovf_chk = 0; of_in = 1;
      tick();
      set_idle(); rs_addr = 5'd3; #1;
      n_total++; if (A !== 32'h7FFFFFFF) $display("FAIL ovf_ignored got=%h exp=7fffffff", A); else n_pass++;
      n_total++; if (wr_blocked !== 1'b0) $display("FAIL ovf_nochk_blk got=%b exp=0", wr_blocked); else n_pass++;
   endtask

   task automatic test_flags();
      flag_en = 1; zf_in = 1; of_in = 0; tick();
      n_total++; if ({zf_q, of_q} !== 2'b10) $display("FAIL flag_set got=%b exp=10", {zf_q, of_q}); else n_pass++;
      flag_en = 0; zf_in = 0; of_in = 1; tick();
      n_total++; if ({zf_q, of_q} !== 2'b10) $display("FAIL flag_hold got=%b exp=10", {zf_q, of_q}); else n_pass++;
      // flags latch even when the same edge blocks a write
      flag_en = 1; zf_in = 0; of_in = 1; w_en = 1; w_addr = 5'd8; w_data = 32'h5; ovf_chk = 1; tick();
      n_total++; if ({zf_q, of_q, wr_blocked} !== 3'b011) $display("FAIL flag_blk got=%b exp=011", {zf_q, of_q, wr_blocked}); else n_pass++;
      set_idle(); #1;
   endtask

   task automatic test_bypass();
      logic [31:0] exp_pre;
      do_write(5'd7, 32'h00001234);
`ifdef RF_WRITE_BYPASS_EN
      exp_pre = 32'hA5A5A5A5;
`else
      exp_pre = 32'h00001234;
`endif
      w_en = 1; w_addr = 5'd7; w_data = 32'hA5A5A5A5; rs_addr = 5'd7; rt_addr = 5'd7; #1;
      n_total++; if (A !== exp_pre) $display("FAIL byp_a got=%h exp=%h", A, exp_pre); else n_pass++;
      n_total++; if (rt_data !== exp_pre) $display("FAIL byp_rt got=%h exp=%h", rt_data, exp_pre); else n_pass++;
      tick(); w_en = 0; #1;
      n_total++; if (A !== 32'hA5A5A5A5) $display("FAIL byp_post got=%h exp=a5a5a5a5", A); else n_pass++;
      set_idle(); #1;
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         rs_addr = 5'($urandom_range(0, 31)); rt_addr = 5'($urandom_range(0, 31));
         w_addr  = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom_range(0, 31));
         w_data  = $urandom(); w_en = 1'($urandom_range(0, 1));
         ovf_chk = 1'($urandom_range(0, 1)); of_in = ($urandom_range(0, 3) == 0);
         zf_in   = 1'($urandom_range(0, 1)); flag_en = 1'($urandom_range(0, 1));
         imm16   = 16'($urandom()); shamt = 5'($urandom_range(0, 31));
         sel_a_shamt = ($urandom_range(0, 3) == 0); sel_b_imm = ($urandom_range(0, 2) == 0);
         imm_sext = 1'($urandom_range(0, 1));
         #1;
         n_total++; if (A !== m_a()) $display("FAIL rnd_a cyc=%0d got=%h exp=%h", c, A, m_a()); else n_pass++;
         n_total++; if (B !== m_b()) $display("FAIL rnd_b cyc=%0d got=%h exp=%h", c, B, m_b()); else n_pass++;
         n_total++; if (rt_data !== m_read(rt_addr)) $display("FAIL rnd_rt cyc=%0d got=%h exp=%h", c, rt_data, m_read(rt_addr)); else n_pass++;
         n_total++; if ({zf_q, of_q, wr_blocked} !== {exp_zf, exp_of, exp_blk})
            $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", c, {zf_q, of_q, wr_blocked}, {exp_zf, exp_of, exp_blk});
         else n_pass++;
         tick();
      end
      set_idle(); #1;
      for (int i = 0; i < 32; i++) begin
         rs_addr = 5'(i); #1;
         n_total++; if (A !== m_read(5'(i))) $display("FAIL rnd_final addr=%0d got=%h exp=%h", i, A, m_read(5'(i))); else n_pass++;
      end
   endtask

   initial begin
      set_idle();
      rst = 1; model_reset();
      #3;
      test_reset();
      test_write_read();
      test_imm();
      test_ovf();
      test_flags();
      test_bypass();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
